// File: rtl/uart_plnk_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_plnk_defs_pkg
// Description : Shared UART definitions for the plnk transmitter and
//               receiver: FSM state encoding, default bit period and the
//               counter widths both ends agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_plnk_defs_pkg;

  // Default bit period in system clocks (e.g. 50 MHz / 115200 baud).
  localparam int c_CLKS_PER_BIT_DEFAULT = 434;

  // Clock counter and bit index widths.
  localparam int c_CNT_W = 12;
  localparam int c_IDX_W = 3;

  // Receiver FSM states, 3-bit encoding. Codes 6 and 7 are unused.
  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_RX_START_BIT = 3'd1,
    s_RX_DATA_BITS = 3'd2,
    s_RX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4,
    s_WAIT_HIGH    = 3'd5
  } rx_state_t;

  // Middle of the start bit: the count at which the start bit is re-checked.
  function automatic logic [c_CNT_W-1:0] half_bit_count(input int clks_per_bit);
    return c_CNT_W'((clks_per_bit - 1) / 2);
  endfunction

endpackage : uart_plnk_defs_pkg
`default_nettype wire

// File: rtl/sync_2ff_plnk.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff_plnk
// Description : Two-flop synchronizer for a single asynchronous input.
//   i_Clock : destination clock
//   i_Rst_L : asynchronous active-low reset, flops load RESET_VAL
//   i_D     : asynchronous input
//   o_Q     : synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff_plnk #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule : sync_2ff_plnk
`default_nettype wire

// File: rtl/uart_rx_plnk.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_plnk
// Description : 8N1 UART receiver, LSB first, no FIFO.
//   i_Clock        : system clock
//   i_Rst_L        : asynchronous active-low reset
//   i_Rx_Serial    : asynchronous serial line, idles high
//   o_Rx_DV        : one-cycle pulse, o_Rx_Byte updated this cycle
//   o_Rx_Byte      : last good byte, held until the next good byte
//   o_Rx_Frame_Err : one-cycle pulse, stop bit sampled low
//   o_Rx_Active    : high whenever a frame is in progress (FSM not idle)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_plnk
  import uart_plnk_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam logic [c_CNT_W-1:0] c_HALF = half_bit_count(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);

  logic                rx_sync;
  rx_state_t           state_q;
  logic [c_CNT_W-1:0]  cnt_q;
  logic [c_IDX_W-1:0]  idx_q;
  logic [7:0]          shift_q;
  logic [7:0]          byte_q;
  logic                dv_q;
  logic                ferr_q;

  // Synchronizer resets to the idle level so reset release never looks
  // like a start edge.
  sync_2ff_plnk #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx_sync)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= s_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        s_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_sync) state_q <= s_RX_START_BIT;
        end

        // Re-check the line mid start bit; a line already high is a glitch.
        s_RX_START_BIT: begin
          if (cnt_q == c_HALF) begin
            cnt_q   <= '0;
            state_q <= rx_sync ? s_IDLE : s_RX_DATA_BITS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Counting from mid start bit, each full period lands mid data bit.
        s_RX_DATA_BITS: begin
          if (cnt_q == c_FULL) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= s_RX_STOP_BIT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        s_RX_STOP_BIT: begin
          if (cnt_q == c_FULL) begin
            cnt_q <= '0;
            if (rx_sync) begin
              byte_q  <= shift_q;
              dv_q    <= 1'b1;
              state_q <= s_CLEANUP;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= s_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        s_CLEANUP: begin
          cnt_q   <= '0;
          state_q <= s_IDLE;
        end

        // A held-low line (break) must not be taken as a new start bit.
        s_WAIT_HIGH: begin
          cnt_q <= '0;
          if (rx_sync) state_q <= s_IDLE;
        end

        default: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= s_IDLE;
        end
      endcase
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = (state_q != s_IDLE);

endmodule : uart_rx_plnk
`default_nettype wire

// File: tb/tb_uart_rx_plnk.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_plnk
// Description : Self-checking bench for uart_rx_plnk. One receiver at 8
//               clocks/bit for functional cases, one at 434 clocks/bit for
//               baud-tolerance cases. Frames are produced by a behavioural
//               serial transmitter; expected results come from the 8N1 rules
//               (good stop -> new byte + DV, bad stop -> frame error, byte kept).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_plnk;

  logic       clk;
  logic       rst_n;
  logic       rx8;
  logic       rx434;

  logic       dv8, ferr8, act8;
  logic [7:0] byte8;
  logic       dv434, ferr434, act434;
  logic [7:0] byte434;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_plnk #(.CLKS_PER_BIT(8)) u_dut8 (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Rx_Serial    (rx8),
    .o_Rx_DV        (dv8),
    .o_Rx_Byte      (byte8),
    .o_Rx_Frame_Err (ferr8),
    .o_Rx_Active    (act8)
  );

  uart_rx_plnk #(.CLKS_PER_BIT(434)) u_dut434 (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Rx_Serial    (rx434),
    .o_Rx_DV        (dv434),
    .o_Rx_Byte      (byte434),
    .o_Rx_Frame_Err (ferr434),
    .o_Rx_Active    (act434)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- output monitor (sampled on falling edge) --------------
  int         dv_cnt8 = 0, ferr_cnt8 = 0, simul8 = 0, byte_glitch8 = 0;
  int         dv_cnt434 = 0, ferr_cnt434 = 0;
  logic [7:0] rxq8[$];
  logic [7:0] prev_byte8 = 8'h00;

  always @(negedge clk) begin
    if (dv8)  begin dv_cnt8++; rxq8.push_back(byte8); end
    if (ferr8) ferr_cnt8++;
    if (dv8 && ferr8) simul8++;
    if (rst_n && (byte8 !== prev_byte8) && !dv8) byte_glitch8++;
    prev_byte8 = byte8;
    if (dv434)   dv_cnt434++;
    if (ferr434) ferr_cnt434++;
  end

  // ---------------- helpers ----------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a line level for a number of clocks; called at posedge+1.
  task automatic hold(input int which, input logic v, input int cycles);
    if (which == 0) rx8 = v; else rx434 = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic stop_ok,
                            input int period);
    hold(which, 1'b0, period);
    for (int i = 0; i < 8; i++) hold(which, d[i], period);
    hold(which, stop_ok, period);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_dv;
    int         exp_ferr;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  int         dv0, fe0;
  logic [7:0] b0;
  logic [7:0] model_last;
  logic [7:0] rnd_b;
  logic       rnd_ok;
  logic [7:0] exp_seq[3];
  logic [7:0] d81;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'h5A};
    vecs[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[4] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[5] = '{8'hE7, 1'b0, 0, 1, 8'h01};

    rst_n = 1'b0;
    rx8   = 1'b1;
    rx434 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_byte8",   32'(byte8), 32'h00);
    check("reset_dv8",     32'(dv8),   32'h0);
    check("reset_ferr8",   32'(ferr8), 32'h0);
    check("reset_active8", 32'(act8),  32'h0);
    check("reset_byte434", 32'(byte434), 32'h00);
    check("reset_active434", 32'(act434), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(0, 1'b1, 10);

    // ---- table-driven frames at 8 clocks/bit ----
    for (int i = 0; i < 6; i++) begin
      dv0 = dv_cnt8; fe0 = ferr_cnt8;
      send_frame(0, vecs[i].data, vecs[i].stop_ok, 8);
      hold(0, 1'b1, 24);
      check($sformatf("vec%0d_dv", i),     32'(dv_cnt8 - dv0),   32'(vecs[i].exp_dv));
      check($sformatf("vec%0d_ferr", i),   32'(ferr_cnt8 - fe0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_byte", i),   32'(byte8),           32'(vecs[i].exp_byte));
      check($sformatf("vec%0d_active", i), 32'(act8),            32'h0);
    end

    // ---- two-cycle low glitch on the idle line ----
    dv0 = dv_cnt8; fe0 = ferr_cnt8; b0 = byte8;
    hold(0, 1'b0, 2);
    hold(0, 1'b1, 2);
    check("glitch_seen_active", 32'(act8), 32'h1);
    hold(0, 1'b1, 20);
    check("glitch_back_idle", 32'(act8), 32'h0);
    check("glitch_no_dv",   32'(dv_cnt8 - dv0),   32'h0);
    check("glitch_no_ferr", 32'(ferr_cnt8 - fe0), 32'h0);
    check("glitch_byte",    32'(byte8),           32'(b0));

    // ---- bad stop bit followed by a 40-cycle break ----
    dv0 = dv_cnt8; fe0 = ferr_cnt8; b0 = byte8;
    send_frame(0, 8'h3C, 1'b0, 8);
    hold(0, 1'b0, 40);
    check("break_active_low_line", 32'(act8), 32'h1);
    check("break_ferr_once", 32'(ferr_cnt8 - fe0), 32'h1);
    check("break_no_dv",     32'(dv_cnt8 - dv0),   32'h0);
    check("break_byte_kept", 32'(byte8),           32'(b0));
    hold(0, 1'b1, 6);
    check("break_released_idle", 32'(act8), 32'h0);
    hold(0, 1'b1, 10);
    check("break_no_retrigger", 32'(dv_cnt8 - dv0), 32'h0);

    // ---- back-to-back frames, no idle gap ----
    exp_seq[0] = 8'h00; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h55;
    rxq8.delete();
    fe0 = ferr_cnt8;
    for (int i = 0; i < 3; i++) send_frame(0, exp_seq[i], 1'b1, 8);
    hold(0, 1'b1, 24);
    check("b2b_count", 32'(rxq8.size()), 32'd3);
    check("b2b_no_ferr", 32'(ferr_cnt8 - fe0), 32'h0);
    for (int i = 0; i < 3; i++)
      if (i < rxq8.size()) check($sformatf("b2b_byte%0d", i), 32'(rxq8[i]), 32'(exp_seq[i]));
      else check($sformatf("b2b_byte%0d_missing", i), 32'h0, 32'h1);

    // ---- reset during data bit 4 of 0x81, then 0x7E ----
    dv0 = dv_cnt8; fe0 = ferr_cnt8;
    d81 = 8'h81;
    hold(0, 1'b0, 8);
    for (int i = 0; i < 4; i++) hold(0, d81[i], 8);
    hold(0, d81[4], 4);
    rst_n = 1'b0;
    #1;
    check("midrst_byte_cleared", 32'(byte8), 32'h00);
    check("midrst_active_cleared", 32'(act8), 32'h0);
    hold(0, 1'b1, 3);
    rst_n = 1'b1;
    hold(0, 1'b1, 80);
    check("midrst_no_dv_81",   32'(dv_cnt8 - dv0),   32'h0);
    check("midrst_no_ferr_81", 32'(ferr_cnt8 - fe0), 32'h0);
    send_frame(0, 8'h7E, 1'b1, 8);
    hold(0, 1'b1, 24);
    check("midrst_dv_7e",   32'(dv_cnt8 - dv0), 32'h1);
    check("midrst_byte_7e", 32'(byte8),         32'h7E);

    // ---- randomized frames against the behavioural model ----
    model_last = byte8;
    for (int n = 0; n < 20; n++) begin
      rnd_b  = 8'($urandom_range(0, 255));
      rnd_ok = ($urandom_range(0, 3) != 0);
      if (rnd_ok) model_last = rnd_b;
      rxq8.delete();
      dv0 = dv_cnt8; fe0 = ferr_cnt8;
      send_frame(0, rnd_b, rnd_ok, 8);
      hold(0, 1'b1, 8 + $urandom_range(4, 20));
      check($sformatf("rnd%0d_dv", n),   32'(dv_cnt8 - dv0),   32'(rnd_ok));
      check($sformatf("rnd%0d_ferr", n), 32'(ferr_cnt8 - fe0), 32'(!rnd_ok));
      check($sformatf("rnd%0d_byte", n), 32'(byte8),           32'(model_last));
      if (rnd_ok && rxq8.size() > 0)
        check($sformatf("rnd%0d_dv_byte", n), 32'(rxq8[0]), 32'(rnd_b));
    end

    check("never_dv_and_ferr",    32'(simul8),       32'h0);
    check("byte_changes_with_dv", 32'(byte_glitch8), 32'h0);

    // ---- 434 clocks/bit with transmitter 3% slow and 3% fast ----
    hold(1, 1'b1, 20);
    dv0 = dv_cnt434; fe0 = ferr_cnt434;
    send_frame(1, 8'hC3, 1'b1, 447);
    hold(1, 1'b1, 600);
    check("slow_dv",   32'(dv_cnt434 - dv0),   32'h1);
    check("slow_ferr", 32'(ferr_cnt434 - fe0), 32'h0);
    check("slow_byte", 32'(byte434),           32'hC3);
    dv0 = dv_cnt434; fe0 = ferr_cnt434;
    send_frame(1, 8'h3C, 1'b1, 421);
    hold(1, 1'b1, 600);
    send_frame(1, 8'hC3, 1'b1, 421);
    hold(1, 1'b1, 600);
    check("fast_dv",   32'(dv_cnt434 - dv0),   32'h2);
    check("fast_ferr", 32'(ferr_cnt434 - fe0), 32'h0);
    check("fast_byte", 32'(byte434),           32'hC3);
    check("fast_idle", 32'(act434),            32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_plnk
`default_nettype wire

// File: doc/uart_rx_plnk.md
UART_RX_PLNK -- requirements
Module: uart_rx_plnk

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clocks per UART bit period (i_Clock frequency / baud); legal range 4..4095.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 i_Clock  input  1  system clock, all logic on rising edge.
REQ-004 i_Rst_L  input  1  asynchronous active-low reset.
REQ-005 i_Rx_Serial  input  1  asynchronous UART line; idles high; 8N1, LSB first.
REQ-006 o_Rx_DV  output  1  one-cycle pulse, o_Rx_Byte valid.
REQ-007 o_Rx_Byte  output  8  last good received byte, held until next good byte.
REQ-008 o_Rx_Frame_Err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 o_Rx_Active  output  1  high whenever the FSM is not in s_IDLE.

Function
REQ-010 i_Rx_Serial SHALL pass through a 2-FF synchronizer before any use; all references below mean the synchronized signal.
REQ-011 FSM states SHALL be s_IDLE, s_RX_START_BIT, s_RX_DATA_BITS, s_RX_STOP_BIT, s_CLEANUP, s_WAIT_HIGH; 3-bit encoding.
REQ-012 Clock counter SHALL be 12 bits, cleared on every state change; bit index SHALL be 3 bits.
REQ-013 s_IDLE: counter and bit index held at 0; line low -> s_RX_START_BIT.
REQ-014 s_RX_START_BIT: count to (CLKS_PER_BIT-1)/2 (integer divide); at that count line low -> s_RX_DATA_BITS, line high -> s_IDLE (glitch rejected, no output pulse).
REQ-015 s_RX_DATA_BITS: count to CLKS_PER_BIT-1, then sample line into shift data bit [bit index]; index < 7 -> increment, stay; index = 7 -> index 0, go to s_RX_STOP_BIT.
REQ-016 s_RX_STOP_BIT: count to CLKS_PER_BIT-1, then sample line; high -> load o_Rx_Byte, pulse o_Rx_DV, go to s_CLEANUP; low -> pulse o_Rx_Frame_Err, o_Rx_Byte unchanged, go to s_WAIT_HIGH.
REQ-017 s_CLEANUP: one cycle, -> s_IDLE.
REQ-018 s_WAIT_HIGH: stay until line high, then -> s_IDLE (break condition does not retrigger reception).
REQ-019 o_Rx_DV and o_Rx_Frame_Err SHALL each be high exactly one cycle per frame, never simultaneously.
REQ-020 o_Rx_DV SHALL assert in the cycle after the stop-bit sample; o_Rx_Byte SHALL change in that same cycle.
REQ-021 Back-to-back frames: a start edge arriving during s_CLEANUP SHALL be detected from s_IDLE with at most 1 extra cycle of latency.
REQ-022 Illegal state encodings SHALL return to s_IDLE on the next clock.

Reset
REQ-023 i_Rst_L low SHALL immediately force: FSM s_IDLE, counter 0, bit index 0, shift data 0, o_Rx_Byte 0x00, o_Rx_DV 0, o_Rx_Frame_Err 0, o_Rx_Active 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no o_Rx_DV or o_Rx_Frame_Err pulse; reception resumes on the first start edge after release.

Structure
REQ-025 FSM state localparams and the default CLKS_PER_BIT SHALL live in the shared include uart_plnk_defs, used by both the transmitter and the receiver.
REQ-026 The synchronizer SHALL be a sub-module sync_2ff_plnk (async active-low reset, reset value parameterized, here 1).
REQ-027 Estimated size 150-250 lines RTL; no FIFO (the consumer must take o_Rx_Byte within one frame time).

Verification (CLKS_PER_BIT=8 unless stated)
REQ-028 Frame 0xA5 driven by the team transmitter at the same CLKS_PER_BIT -> one o_Rx_DV pulse, o_Rx_Byte=0xA5, no o_Rx_Frame_Err.
REQ-029 Low glitch of 2 cycles on idle line -> FSM returns to s_IDLE, no pulses, o_Rx_Byte unchanged.
REQ-030 Frame 0x3C with stop bit forced low, line then held low 40 cycles -> one o_Rx_Frame_Err pulse, o_Rx_Byte still previous value, o_Rx_Active high until line goes high.
REQ-031 Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three o_Rx_DV pulses with matching bytes.
REQ-032 i_Rst_L pulsed low during data bit 4 of 0x81, then frame 0x7E -> no pulse for 0x81, o_Rx_Byte=0x7E.
REQ-033 CLKS_PER_BIT=434, transmitter bit period +/-3% -> 0xC3 received correctly both ways.
